// File: rtl/cv32e40p_tmr_vote_monitor.sv
// TMR word voter: per-replica mismatch attribution, isolation of persistent faults and DMR fallback.
// Optional corrected-error counter is built only when CV32E40P_TMR_ERR_CNT_EN is defined.
module cv32e40p_tmr_vote_monitor #(
    parameter int WIDTH        = 32,
    parameter int FAULT_THRESH = 3,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] res0_i,
    input  logic [WIDTH-1:0] res1_i,
    input  logic [WIDTH-1:0] res2_i,
    output logic [WIDTH-1:0] result_o,
    output logic             mismatch_o,
    output logic             uncorrectable_o,
    output logic [5:0]       replica_state_o,
    output logic             degraded_o,
    output logic [CNT_W-1:0] corrected_cnt_o
);

    localparam int FCNT_W = $clog2(FAULT_THRESH + 1);

    typedef enum logic [1:0] {
        ST_HEALTHY  = 2'b00,
        ST_SUSPECT  = 2'b01,
        ST_ISOLATED = 2'b10
    } rep_state_e;

    function automatic logic [WIDTH-1:0] f_majority(input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b,
                                                    input logic [WIDTH-1:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic [1:0] f_popcount3(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

    rep_state_e        r_state [3];
    logic [FCNT_W-1:0] r_fcnt  [3];
    logic              r_degraded;

    logic [WIDTH-1:0]  w_res   [3];
    logic [WIDTH-1:0]  w_maj;
    logic [WIDTH-1:0]  w_dmr_a;
    logic [WIDTH-1:0]  w_dmr_b;
    logic [2:0]        w_iso;
    logic [2:0]        w_mis;
    logic [2:0]        w_to_iso;
    logic [1:0]        w_n_iso;
    logic [1:0]        w_n_mis;
    logic              w_tmr;
    logic              w_upd;

    assign w_res[0] = res0_i;
    assign w_res[1] = res1_i;
    assign w_res[2] = res2_i;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_iso[i] = (r_state[i] == ST_ISOLATED);
        end
    end

    assign w_n_iso = f_popcount3(w_iso);
    assign w_tmr   = (w_n_iso == 2'd0);
    assign w_maj   = f_majority(res0_i, res1_i, res2_i);

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_mis[i] = w_tmr && (w_res[i] != w_maj);
        end
    end

    assign w_n_mis = f_popcount3(w_mis);

    // In DMR the surviving pair is (lower index, higher index) of the non-isolated replicas
    always_comb begin
        w_dmr_a = res0_i;
        w_dmr_b = res1_i;
        if (w_iso[0]) begin
            w_dmr_a = w_iso[1] ? res2_i : res1_i;
            w_dmr_b = res2_i;
        end else if (w_iso[1]) begin
            w_dmr_b = res2_i;
        end
    end

    always_comb begin
        result_o        = w_maj;
        mismatch_o      = 1'b0;
        uncorrectable_o = 1'b0;
        if (w_tmr) begin
            mismatch_o      = valid_i && (w_n_mis != 2'd0);
            uncorrectable_o = valid_i && (w_n_mis >= 2'd2);
        end else begin
            result_o        = w_dmr_a;
            mismatch_o      = valid_i && (w_n_iso == 2'd1) && (w_dmr_a != w_dmr_b);
            uncorrectable_o = mismatch_o;
        end
    end

    // Attribution only happens in TMR with at most one dissenting replica
    assign w_upd = valid_i && !clear_i && w_tmr && (w_n_mis < 2'd2);

    always_comb begin
        w_to_iso = '0;
        for (int i = 0; i < 3; i++) begin
            if (w_upd && w_mis[i]) begin
                if (r_state[i] == ST_HEALTHY) begin
                    w_to_iso[i] = (FAULT_THRESH == 1);
                end else if (r_state[i] == ST_SUSPECT) begin
                    w_to_iso[i] = (int'(r_fcnt[i]) + 1 >= FAULT_THRESH);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                r_state[i] <= ST_HEALTHY;
                r_fcnt[i]  <= '0;
            end
            r_degraded <= 1'b0;
        end else if (clear_i) begin
            for (int i = 0; i < 3; i++) begin
                r_state[i] <= ST_HEALTHY;
                r_fcnt[i]  <= '0;
            end
            r_degraded <= 1'b0;
        end else if (w_upd) begin
            for (int i = 0; i < 3; i++) begin
                case (r_state[i])
                    ST_HEALTHY: begin
                        if (w_mis[i]) begin
                            if (w_to_iso[i]) begin
                                r_state[i] <= ST_ISOLATED;
                            end else begin
                                r_state[i] <= ST_SUSPECT;
                            end
                            r_fcnt[i] <= FCNT_W'(1);
                        end
                    end
                    ST_SUSPECT: begin
                        if (w_mis[i]) begin
                            r_fcnt[i] <= r_fcnt[i] + FCNT_W'(1);
                            if (w_to_iso[i]) begin
                                r_state[i] <= ST_ISOLATED;
                            end
                        end else begin
                            r_state[i] <= ST_HEALTHY;
                            r_fcnt[i]  <= '0;
                        end
                    end
                    default: ;
                endcase
            end
            if (|w_to_iso) begin
                r_degraded <= 1'b1;
            end
        end
    end

    assign replica_state_o = {r_state[2], r_state[1], r_state[0]};
    assign degraded_o      = r_degraded;

`ifdef CV32E40P_TMR_ERR_CNT_EN
    logic [CNT_W-1:0] r_corr_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_corr_cnt <= '0;
        end else if (clear_i) begin
            r_corr_cnt <= '0;
        end else if (w_upd && (w_n_mis == 2'd1) && (r_corr_cnt != {CNT_W{1'b1}})) begin
            r_corr_cnt <= r_corr_cnt + CNT_W'(1);
        end
    end

    assign corrected_cnt_o = r_corr_cnt;
`else
    assign corrected_cnt_o = '0;
`endif

endmodule
